// File: rtl/pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// PipelineHazardCtrl (top module name: pipeline_hazard_ctrl)
//
// Central sequencer for the pipeline registers of the 5-stage 64-bit core
// (IF/ID, ID/EX, EX/MEM, MEM/WB). Per-stage enables and flushes are derived
// from three hazard sources:
//   - a multi-cycle data-memory handshake (highest priority, freezes the pipe)
//   - a taken branch resolved in EX (squashes IF/ID and ID/EX)
//   - a load-use dependency detected in ID (one bubble into ID/EX)
// It also keeps a sticky memory-timeout flag and a saturating count of the
// cycles in which the PC was held.
//
// Parameters
//   TIMEOUT_CYC  maximum length in cycles of one memory access before abort (>=2)
//   CNT_W        width of stall_count_o
//
// Ports
//   clk               in   clock, rising edge
//   reset             in   synchronous, active-high reset
//   id_rs1_i          in   [4:0] rs1 of the instruction in ID
//   id_rs2_i          in   [4:0] rs2 of the instruction in ID
//   id_uses_rs2_i     in   ID instruction reads rs2
//   idex_memread_i    in   ID/EX holds a load
//   idex_rd_i         in   [4:0] ID/EX destination register
//   ex_branch_tkn_i   in   branch in EX resolved taken
//   exmem_memread_i   in   EX/MEM holds a load
//   exmem_memwrite_i  in   EX/MEM holds a store
//   dmem_ready_i      in   data memory completes the access this cycle
//   dmem_req_o        out  data-memory access request
//   pc_en_o           out  PC load enable
//   ifid_en_o         out  IF/ID enable
//   ifid_flush_o      out  IF/ID flush to bubble
//   idex_en_o         out  ID/EX enable
//   idex_flush_o      out  ID/EX flush to bubble
//   exmem_en_o        out  EX/MEM enable
//   memwb_flush_o     out  bubble into MEM/WB (clears RegWrite/MemtoReg)
//   timeout_err_o     out  sticky: a memory access was aborted
//   stall_count_o     out  [CNT_W-1:0] cycles with pc_en_o=0, saturating
// -----------------------------------------------------------------------------
module pipeline_hazard_ctrl #(
  parameter int TIMEOUT_CYC = 256,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs1_i,
  input  logic [4:0]       id_rs2_i,
  input  logic             id_uses_rs2_i,
  input  logic             idex_memread_i,
  input  logic [4:0]       idex_rd_i,
  input  logic             ex_branch_tkn_i,
  input  logic             exmem_memread_i,
  input  logic             exmem_memwrite_i,
  input  logic             dmem_ready_i,
  output logic             dmem_req_o,
  output logic             pc_en_o,
  output logic             ifid_en_o,
  output logic             ifid_flush_o,
  output logic             idex_en_o,
  output logic             idex_flush_o,
  output logic             exmem_en_o,
  output logic             memwb_flush_o,
  output logic             timeout_err_o,
  output logic [CNT_W-1:0] stall_count_o
);

  // The wait counter never exceeds TIMEOUT_CYC-1, so clog2 bits suffice.
  localparam int WCW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [WCW-1:0] WAIT_LAST = WCW'(TIMEOUT_CYC - 1);

  typedef enum logic {
    RUN,
    MEM_WAIT
  } state_e;

  state_e           state_q, state_d;
  logic [WCW-1:0]   wait_cnt_q, wait_cnt_d;
  logic             timeout_err_q, timeout_err_d;
  logic [CNT_W-1:0] stall_count_q, stall_count_d;

  logic mem_acc;
  logic load_use;

  assign mem_acc = exmem_memread_i | exmem_memwrite_i;

  // x0 is hardwired to zero, so a load targeting it never creates a hazard.
  assign load_use = idex_memread_i && (idex_rd_i != 5'd0) &&
                    ((idex_rd_i == id_rs1_i) ||
                     (id_uses_rs2_i && (idex_rd_i == id_rs2_i)));

  // Next-state and Mealy outputs. Priority in RUN is memory freeze, then a
  // taken branch (which squashes the ID instruction, so any load-use it would
  // raise is moot), then load-use. In MEM_WAIT only the handshake matters;
  // branch and load-use are re-evaluated once back in RUN. The abort on
  // timeout releases the pipe exactly like a normal completion.
  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    timeout_err_d = timeout_err_q;
    dmem_req_o    = 1'b0;
    pc_en_o       = 1'b1;
    ifid_en_o     = 1'b1;
    ifid_flush_o  = 1'b0;
    idex_en_o     = 1'b1;
    idex_flush_o  = 1'b0;
    exmem_en_o    = 1'b1;
    memwb_flush_o = 1'b0;

    case (state_q)
      RUN: begin
        dmem_req_o = mem_acc;
        if (mem_acc && !dmem_ready_i) begin
          pc_en_o       = 1'b0;
          ifid_en_o     = 1'b0;
          idex_en_o     = 1'b0;
          exmem_en_o    = 1'b0;
          memwb_flush_o = 1'b1;
          state_d       = MEM_WAIT;
          wait_cnt_d    = WCW'(1);
        end else if (ex_branch_tkn_i) begin
          ifid_flush_o = 1'b1;
          idex_flush_o = 1'b1;
        end else if (load_use) begin
          pc_en_o      = 1'b0;
          ifid_en_o    = 1'b0;
          idex_flush_o = 1'b1;
        end
      end
      MEM_WAIT: begin
        dmem_req_o = 1'b1;
        if (dmem_ready_i) begin
          state_d    = RUN;
          wait_cnt_d = '0;
        end else if (wait_cnt_q == WAIT_LAST) begin
          state_d       = RUN;
          wait_cnt_d    = '0;
          timeout_err_d = 1'b1;
        end else begin
          pc_en_o       = 1'b0;
          ifid_en_o     = 1'b0;
          idex_en_o     = 1'b0;
          exmem_en_o    = 1'b0;
          memwb_flush_o = 1'b1;
          wait_cnt_d    = wait_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d    = RUN;
        wait_cnt_d = '0;
      end
    endcase

    // Reset overrides everything so the pipe is filled with bubbles while held.
    if (reset) begin
      dmem_req_o    = 1'b0;
      pc_en_o       = 1'b0;
      ifid_en_o     = 1'b0;
      idex_en_o     = 1'b0;
      exmem_en_o    = 1'b0;
      ifid_flush_o  = 1'b1;
      idex_flush_o  = 1'b1;
      memwb_flush_o = 1'b1;
    end
  end

  // Saturating stall counter: counts every cycle the PC is held.
  always_comb begin
    stall_count_d = stall_count_q;
    if (!pc_en_o && (stall_count_q != {CNT_W{1'b1}})) begin
      stall_count_d = stall_count_q + 1'b1;
    end
  end

  // State and counter registers with synchronous reset; a reset during
  // MEM_WAIT simply abandons the access without flagging a timeout.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= RUN;
      wait_cnt_q    <= '0;
      timeout_err_q <= 1'b0;
      stall_count_q <= '0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      timeout_err_q <= timeout_err_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign timeout_err_o = timeout_err_q;
  assign stall_count_o = stall_count_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// TbPipelineHazardCtrl (module tb_pipeline_hazard_ctrl)
//
// Directed bench for pipeline_hazard_ctrl with TIMEOUT_CYC=4 and CNT_W=4 so
// that the abort and the counter saturation are reachable in a few cycles.
// Inputs change on the falling edge; outputs are read 1 time unit later.
// The eight pipeline-control outputs are packed as
//   {dmem_req, pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_flush}
// -----------------------------------------------------------------------------
module tb_pipeline_hazard_ctrl;

  localparam logic [7:0] O_IDLE    = 8'h6A; // all enables, no flush, no request
  localparam logic [7:0] O_MEMGO   = 8'hEA; // same as idle with request held
  localparam logic [7:0] O_RESET   = 8'h15; // enables low, all flushes high
  localparam logic [7:0] O_FREEZE  = 8'h81; // request, enables low, MEM/WB bubble
  localparam logic [7:0] O_BRANCH  = 8'h7E; // enables high, IF/ID and ID/EX flushed
  localparam logic [7:0] O_LOADUSE = 8'h0E; // PC and IF/ID held, ID/EX bubble

  logic       clk;
  logic       reset;
  logic [4:0] id_rs1, id_rs2, idex_rd;
  logic       id_uses_rs2, idex_memread, ex_branch_tkn;
  logic       exmem_memread, exmem_memwrite, dmem_ready;
  logic       dmem_req, pc_en, ifid_en, ifid_flush, idex_en, idex_flush;
  logic       exmem_en, memwb_flush, timeout_err;
  logic [3:0] stall_count;
  logic [7:0] outs;

  int nChecks;
  int nFail;

  assign outs = {dmem_req, pc_en, ifid_en, ifid_flush, idex_en, idex_flush,
                 exmem_en, memwb_flush};

  pipeline_hazard_ctrl #(
    .TIMEOUT_CYC(4),
    .CNT_W      (4)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .id_rs1_i         (id_rs1),
    .id_rs2_i         (id_rs2),
    .id_uses_rs2_i    (id_uses_rs2),
    .idex_memread_i   (idex_memread),
    .idex_rd_i        (idex_rd),
    .ex_branch_tkn_i  (ex_branch_tkn),
    .exmem_memread_i  (exmem_memread),
    .exmem_memwrite_i (exmem_memwrite),
    .dmem_ready_i     (dmem_ready),
    .dmem_req_o       (dmem_req),
    .pc_en_o          (pc_en),
    .ifid_en_o        (ifid_en),
    .ifid_flush_o     (ifid_flush),
    .idex_en_o        (idex_en),
    .idex_flush_o     (idex_flush),
    .exmem_en_o       (exmem_en),
    .memwb_flush_o    (memwb_flush),
    .timeout_err_o    (timeout_err),
    .stall_count_o    (stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive every hazard input at once, then let the combinational outputs settle.
  task automatic applyStimulus(input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic u2, input logic imr,
                               input logic [4:0] ird, input logic br,
                               input logic emr, input logic emw,
                               input logic rdy);
    id_rs1         = rs1;
    id_rs2         = rs2;
    id_uses_rs2    = u2;
    idex_memread   = imr;
    idex_rd        = ird;
    ex_branch_tkn  = br;
    exmem_memread  = emr;
    exmem_memwrite = emw;
    dmem_ready     = rdy;
    #1;
  endtask

  // Advance to the next falling edge (one rising edge in between).
  task automatic stepCycle();
    @(negedge clk);
  endtask

  task automatic doReset();
    @(negedge clk);
    reset = 1'b1;
    applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    stepCycle();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1;
    applyStimulus(5'd3, 5'd4, 1'b1, 1'b1, 5'd3, 1'b1, 1'b1, 1'b0, 1'b0);
    nChecks++;
    if (outs !== O_RESET) begin
      nFail++;
      $display("[TB] FAIL reset_outs: got %h expected %h", outs, O_RESET);
    end
    stepCycle();
    stepCycle();
    nChecks++;
    if (stall_count !== 4'd0 || timeout_err !== 1'b0) begin
      nFail++;
      $display("[TB] FAIL reset_regs: got cnt=%0d tmo=%b expected cnt=0 tmo=0",
               stall_count, timeout_err);
    end
    reset = 1'b0;
    applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    nChecks++;
    if (outs !== O_IDLE) begin
      nFail++;
      $display("[TB] FAIL post_reset_idle: got %h expected %h", outs, O_IDLE);
    end
  endtask

  task automatic test_load_use();
    doReset();
    // ld x5 in ID/EX, add x6,x5,x1 in ID
    applyStimulus(5'd5, 5'd1, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b1);
    nChecks++;
    if (outs !== O_LOADUSE) begin
      nFail++;
      $display("[TB] FAIL load_use_rs1: got %h expected %h", outs, O_LOADUSE);
    end
    stepCycle();
    // load now in EX/MEM (zero-wait), bubble in ID/EX
    applyStimulus(5'd5, 5'd1, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1);
    nChecks++;
    if (outs !== O_MEMGO) begin
      nFail++;
      $display("[TB] FAIL load_use_clears: got %h expected %h", outs, O_MEMGO);
    end
    nChecks++;
    if (stall_count !== 4'd1) begin
      nFail++;
      $display("[TB] FAIL load_use_count: got %0d expected 1", stall_count);
    end
    stepCycle();
    // dependency through rs2
    applyStimulus(5'd3, 5'd7, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0);
    nChecks++;
    if (outs !== O_LOADUSE) begin
      nFail++;
      $display("[TB] FAIL load_use_rs2: got %h expected %h", outs, O_LOADUSE);
    end
    stepCycle();
  endtask

  task automatic test_no_hazard();
    doReset();
    applyStimulus(5'd0, 5'd2, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    nChecks++;
    if (outs !== O_IDLE) begin
      nFail++;
      $display("[TB] FAIL x0_dest: got %h expected %h", outs, O_IDLE);
    end
    stepCycle();
    applyStimulus(5'd1, 5'd9, 1'b0, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0);
    nChecks++;
    if (outs !== O_IDLE) begin
      nFail++;
      $display("[TB] FAIL rs2_unused: got %h expected %h", outs, O_IDLE);
    end
    stepCycle();
    applyStimulus(5'd9, 5'd9, 1'b1, 1'b0, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0);
    nChecks++;
    if (outs !== O_IDLE) begin
      nFail++;
      $display("[TB] FAIL not_load: got %h expected %h", outs, O_IDLE);
    end
    stepCycle();
    nChecks++;
    if (stall_count !== 4'd0) begin
      nFail++;
      $display("[TB] FAIL no_hazard_count: got %0d expected 0", stall_count);
    end
  endtask

  task automatic test_mem_wait();
    doReset();
    // store, ready low for 3 cycles, branch input present but must be ignored
    for (int i = 0; i < 3; i++) begin
      applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, (i == 1), 1'b0, 1'b1, 1'b0);
      nChecks++;
      if (outs !== O_FREEZE) begin
        nFail++;
        $display("[TB] FAIL store_freeze_%0d: got %h expected %h", i, outs, O_FREEZE);
      end
      stepCycle();
    end
    applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    nChecks++;
    if (outs !== O_MEMGO) begin
      nFail++;
      $display("[TB] FAIL store_release: got %h expected %h", outs, O_MEMGO);
    end
    stepCycle();
    applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    nChecks++;
    if (outs !== O_IDLE || stall_count !== 4'd3 || timeout_err !== 1'b0) begin
      nFail++;
      $display("[TB] FAIL store_after: got outs=%h cnt=%0d tmo=%b expected outs=%h cnt=3 tmo=0",
               outs, stall_count, timeout_err, O_IDLE);
    end
  endtask

  task automatic test_branch_load_use();
    doReset();
    applyStimulus(5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    nChecks++;
    if (outs !== O_BRANCH) begin
      nFail++;
      $display("[TB] FAIL branch_over_load_use: got %h expected %h", outs, O_BRANCH);
    end
    stepCycle();
    nChecks++;
    if (stall_count !== 4'd0) begin
      nFail++;
      $display("[TB] FAIL branch_count: got %0d expected 0", stall_count);
    end
    // a pending memory stall outranks the branch
    applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    nChecks++;
    if (outs !== O_FREEZE) begin
      nFail++;
      $display("[TB] FAIL freeze_over_branch: got %h expected %h", outs, O_FREEZE);
    end
    stepCycle();
  endtask

  task automatic test_timeout();
    doReset();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
      nChecks++;
      if (outs !== O_FREEZE) begin
        nFail++;
        $display("[TB] FAIL tmo_freeze_%0d: got %h expected %h", i, outs, O_FREEZE);
      end
      stepCycle();
    end
    // fourth cycle of the access: aborted and released
    applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    nChecks++;
    if (outs !== O_MEMGO || timeout_err !== 1'b0) begin
      nFail++;
      $display("[TB] FAIL tmo_abort: got outs=%h tmo=%b expected outs=%h tmo=0",
               outs, timeout_err, O_MEMGO);
    end
    stepCycle();
    applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    nChecks++;
    if (outs !== O_IDLE || timeout_err !== 1'b1 || stall_count !== 4'd3) begin
      nFail++;
      $display("[TB] FAIL tmo_flag: got outs=%h tmo=%b cnt=%0d expected outs=%h tmo=1 cnt=3",
               outs, timeout_err, stall_count, O_IDLE);
    end
    stepCycle();
    stepCycle();
    nChecks++;
    if (timeout_err !== 1'b1) begin
      nFail++;
      $display("[TB] FAIL tmo_sticky: got %b expected 1", timeout_err);
    end
    doReset();
    #1;
    nChecks++;
    if (timeout_err !== 1'b0) begin
      nFail++;
      $display("[TB] FAIL tmo_cleared: got %b expected 0", timeout_err);
    end
  endtask

  task automatic test_reset_mid_wait();
    doReset();
    applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    stepCycle();
    stepCycle();
    // second MEM_WAIT cycle
    reset = 1'b1;
    applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    nChecks++;
    if (outs !== O_RESET) begin
      nFail++;
      $display("[TB] FAIL mid_wait_reset_outs: got %h expected %h", outs, O_RESET);
    end
    stepCycle();
    reset = 1'b0;
    applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    nChecks++;
    if (outs !== O_IDLE || stall_count !== 4'd0 || timeout_err !== 1'b0) begin
      nFail++;
      $display("[TB] FAIL mid_wait_after: got outs=%h cnt=%0d tmo=%b expected outs=%h cnt=0 tmo=0",
               outs, stall_count, timeout_err, O_IDLE);
    end
    stepCycle();
  endtask

  task automatic test_back_to_back();
    doReset();
    // one-cycle wait, then a new access right behind it
    applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    stepCycle();
    applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1);
    stepCycle();
    applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    nChecks++;
    if (outs !== O_FREEZE || stall_count !== 4'd1) begin
      nFail++;
      $display("[TB] FAIL back_to_back: got outs=%h cnt=%0d expected outs=%h cnt=1",
               outs, stall_count, O_FREEZE);
    end
    applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    stepCycle();
  endtask

  task automatic test_saturation();
    doReset();
    // held load-use keeps pc_en low; the 4-bit counter must stop at 15
    applyStimulus(5'd4, 5'd0, 1'b0, 1'b1, 5'd4, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 15; i++) stepCycle();
    nChecks++;
    if (stall_count !== 4'd15) begin
      nFail++;
      $display("[TB] FAIL sat_reach: got %0d expected 15", stall_count);
    end
    for (int i = 0; i < 5; i++) stepCycle();
    nChecks++;
    if (stall_count !== 4'd15) begin
      nFail++;
      $display("[TB] FAIL sat_hold: got %0d expected 15", stall_count);
    end
  endtask

  initial begin
    nChecks = 0;
    nFail   = 0;
    reset   = 1'b1;
    id_rs1 = '0; id_rs2 = '0; id_uses_rs2 = 1'b0; idex_memread = 1'b0;
    idex_rd = '0; ex_branch_tkn = 1'b0; exmem_memread = 1'b0;
    exmem_memwrite = 1'b0; dmem_ready = 1'b0;
    test_reset();
    test_load_use();
    test_no_hazard();
    test_mem_wait();
    test_branch_load_use();
    test_timeout();
    test_reset_mid_wait();
    test_back_to_back();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
